// File: rtl/rtr_pkg.sv
// Shared router types: output-port codes and the buffered flit record.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rtr_pkg;

    // Output-port codes as seen by the switch allocator.
    localparam int unsigned PORT_LOCAL = 0;
    localparam int unsigned PORT_N     = 1;
    localparam int unsigned PORT_S     = 2;
    localparam int unsigned PORT_E     = 3;
    localparam int unsigned PORT_W     = 4;

    // The flit record is sized for the widest router in the family; narrower
    // instances zero-extend into it and synthesis trims the constant bits.
    localparam int unsigned FLIT_DEST_MAX = 8;
    localparam int unsigned FLIT_DATA_MAX = 64;

    typedef struct packed {
        logic                     head;
        logic                     tail;
        logic [FLIT_DEST_MAX-1:0] dest;
        logic [FLIT_DATA_MAX-1:0] data;
    } flit_t;

endpackage

// File: rtl/input_route_stage_if.sv
// Upstream flit channel plus switch-side request channel of one input port.
// Latency: n/a (wires only).
// Backpressure: in_ready throttles the sender, out_ready throttles the stage.
interface input_route_stage_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int RTR_ADDR_WIDTH = 2,
    parameter int ROUTE_WIDTH    = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic                      in_head;
    logic                      in_tail;
    logic [RTR_ADDR_WIDTH-1:0] in_dest;
    logic [DATA_WIDTH-1:0]     in_data;

    logic                      out_valid;
    logic                      out_ready;
    logic [ROUTE_WIDTH-1:0]    out_port;
    logic                      out_head;
    logic                      out_tail;
    logic [DATA_WIDTH-1:0]     out_data;

    // Environment side: sends flits, consumes routed requests.
    modport master (
        output in_valid, in_head, in_tail, in_dest, in_data, out_ready,
        input  in_ready, out_valid, out_port, out_head, out_tail, out_data
    );

    // Route-stage side.
    modport slave (
        input  in_valid, in_head, in_tail, in_dest, in_data, out_ready,
        output in_ready, out_valid, out_port, out_head, out_tail, out_data
    );
endinterface

// File: rtl/input_route_stage_flit_fifo.sv
// Strict-order flit buffer with combinational front and registered ready.
// Latency: a pushed word is at the front the cycle after the push.
// Backpressure: ready is low while full; a same-cycle pop does not reopen it early.
module flit_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             ready,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Occupancy after this cycle's transfers; push+pop leaves it unchanged.
    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_next = count - CW'(1);
        end
    end

    // Pointers wrap naturally at DEPTH; ready is the registered not-full flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_next;
            ready <= (count_next != CW'(DEPTH));
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/input_route_stage.sv
// Input-port route stage: buffers flits and tags each packet with its output port.
// Latency: head pushed in cycle N is presented with its route in cycle N+2.
// Backpressure: out_ready stalls the front flit; full buffer drops in_ready.
module input_route_stage
    import rtr_pkg::*;
#(
    parameter int NUM_ROWS       = 2,
    parameter int NUM_COLS       = 2,
    parameter int ROUTE_WIDTH    = 4,
    parameter int RTR_ADDR_WIDTH = $clog2(NUM_ROWS*NUM_COLS),
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [0:NUM_ROWS*NUM_COLS-1][ROUTE_WIDTH-1:0] routing_table,
    input_route_stage_if.slave                          bus,
    output logic                                        err_orphan,
    output logic                                        err_dest
);
    localparam int NUM_DEST = NUM_ROWS * NUM_COLS;
    localparam int IDXW     = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                    state, state_next;
    logic [ROUTE_WIDTH-1:0]    port_q, port_next;
    logic [ROUTE_WIDTH-1:0]    lookup;
    logic                      dest_bad;
    logic                      fwd;
    logic                      push, pop, fifo_ready, empty;
    logic [RTR_ADDR_WIDTH-1:0] in_dest;
    flit_t                     wr_flit, front;
    logic                      unused_front;

    assign in_dest      = bus.in_dest;
    assign push         = bus.in_valid && fifo_ready;
    assign unused_front = ^front.data;

    // Zero-extend the incoming flit into the shared record.
    always_comb begin
        wr_flit      = '0;
        wr_flit.head = bus.in_head;
        wr_flit.tail = bus.in_tail;
        wr_flit.dest = FLIT_DEST_MAX'(in_dest);
        wr_flit.data = FLIT_DATA_MAX'(bus.in_data);
    end

    flit_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(flit_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (wr_flit),
        .pop     (pop),
        .rd_data (front),
        .ready   (fifo_ready),
        .empty   (empty)
    );

    // Table lookup for the front flit; unknown destinations go to the local port.
    always_comb begin
        lookup   = ROUTE_WIDTH'(PORT_LOCAL);
        dest_bad = 1'b1;
        for (int i = 0; i < NUM_DEST; i++) begin
            if (front.dest == FLIT_DEST_MAX'(i)) begin
                lookup   = routing_table[IDXW'(i)];
                dest_bad = 1'b0;
            end
        end
    end

    // Route FSM: latch the port on a head, forward until the tail leaves.
    always_comb begin
        state_next = state;
        port_next  = port_q;
        pop        = 1'b0;
        fwd        = 1'b0;
        err_orphan = 1'b0;
        err_dest   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    if (front.head) begin
                        port_next  = lookup;
                        err_dest   = dest_bad;
                        state_next = ACTIVE;
                    end else begin
                        pop        = 1'b1;
                        err_orphan = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                fwd = !empty;
                pop = !empty && bus.out_ready;
                if (pop && front.tail) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State and latched route; reset forgets any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            port_q <= '0;
        end else begin
            state  <= state_next;
            port_q <= port_next;
        end
    end

    assign bus.in_ready  = fifo_ready;
    assign bus.out_valid = fwd;
    assign bus.out_port  = port_q;
    assign bus.out_head  = fwd && front.head;
    assign bus.out_tail  = fwd && front.tail;
    assign bus.out_data  = fwd ? front.data[DATA_WIDTH-1:0] : '0;
endmodule

// File: tb/tb_input_route_stage.sv
// Directed bench for input_route_stage on router 0 of a 2x2 mesh.
// Latency: n/a.
// Backpressure: out_ready is driven per scenario.
module tb_input_route_stage;

    typedef struct packed {
        logic [3:0]  port;
        logic        head;
        logic        tail;
        logic [31:0] data;
    } oflit_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [0:3][3:0]  rt;
    logic             err_orphan, err_dest;

    always #5 clk = ~clk;

    input_route_stage_if #(.DATA_WIDTH(32), .RTR_ADDR_WIDTH(3), .ROUTE_WIDTH(4)) bus ();

    input_route_stage #(
        .NUM_ROWS(2), .NUM_COLS(2), .ROUTE_WIDTH(4),
        .RTR_ADDR_WIDTH(3), .DATA_WIDTH(32), .FIFO_DEPTH(4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .routing_table (rt),
        .bus           (bus),
        .err_orphan    (err_orphan),
        .err_dest      (err_dest)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int first_valid_cyc = -1;
    int exp_orphans = 0, exp_dest_errs = 0;
    int seen_orphans = 0, seen_dest_errs = 0;
    oflit_t exp_q[$];
    oflit_t log_q[$];
    logic in_pkt = 1'b0;
    logic [3:0] pkt_port = 4'd0;
    logic prev_valid = 1'b0, prev_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Packet-level model: orphans vanish, a head fixes the port for its packet.
    function automatic void model_accept(input logic h, input logic t,
                                         input logic [2:0] d, input logic [31:0] dat);
        oflit_t f;
        if (!in_pkt && !h) begin
            exp_orphans++;
            return;
        end
        if (!in_pkt) begin
            in_pkt = 1'b1;
            if (d < 3'd4) pkt_port = rt[d[1:0]];
            else begin
                pkt_port = 4'd0;
                exp_dest_errs++;
            end
        end
        f.port = pkt_port; f.head = h; f.tail = t; f.data = dat;
        exp_q.push_back(f);
        if (t) in_pkt = 1'b0;
    endfunction

    // Per-cycle comparison of the switch-side outputs against the model stream.
    always @(negedge clk) begin
        oflit_t act;
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (err_orphan) seen_orphans++;
            if (err_dest) seen_dest_errs++;
            if (prev_valid && !prev_ready) check("valid_hold", bus.out_valid, 1'b1);
            if (bus.out_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                act.port = bus.out_port; act.head = bus.out_head;
                act.tail = bus.out_tail; act.data = bus.out_data;
                check("flit_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    check("out_flit", act, exp_q[0]);
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        log_q.push_back(act);
                    end
                end
            end
            prev_valid = bus.out_valid;
            prev_ready = bus.out_ready;
        end
    end

    task automatic send(input logic h, input logic t, input logic [2:0] d,
                        input logic [31:0] dat, output int pcyc);
        bus.in_valid = 1'b1; bus.in_head = h; bus.in_tail = t;
        bus.in_dest = d; bus.in_data = dat;
        pcyc = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                pcyc = cyc;
                model_accept(h, t, d, dat);
                break;
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (pcyc < 0) begin
            tests++; fails++;
            $display("FAIL send_timeout: in_ready never rose for data %0h", dat);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.out_valid) break;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        repeat (2) @(negedge clk);
        check({name, "_orphans"}, seen_orphans, exp_orphans);
        check({name, "_desterr"}, seen_dest_errs, exp_dest_errs);
        @(posedge clk); #1;
    endtask

    initial begin
        int p0, p;
        logic acc;
        bus.in_valid = 1'b0; bus.in_head = 1'b0; bus.in_tail = 1'b0;
        bus.in_dest = 3'd0; bus.in_data = 32'd0; bus.out_ready = 1'b1;
        rt = {4'd0, 4'd3, 4'd2, 4'd3};

        // Reset values
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_port", bus.out_port, 4'd0);
        check("rst_out_flit", {bus.out_head, bus.out_tail, bus.out_data}, 34'd0);
        check("rst_errs", {err_orphan, err_dest}, 2'b00);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("ready_before_edge", bus.in_ready, 1'b0);
        @(negedge clk);
        check("ready_after_edge", bus.in_ready, 1'b1);
        @(posedge clk); #1;

        // 3-flit packet to dest 2
        log_q.delete(); first_valid_cyc = -1;
        send(1'b1, 1'b0, 3'd2, 32'hA1, p0);
        send(1'b0, 1'b0, 3'd2, 32'hA2, p);
        send(1'b0, 1'b1, 3'd2, 32'hA3, p);
        wait_drain("pkt3");
        check("pkt3_latency", first_valid_cyc - p0, 2);
        check("pkt3_count", log_q.size(), 3);
        if (log_q.size() == 3) begin
            check("pkt3_f0", log_q[0], {4'd2, 1'b1, 1'b0, 32'hA1});
            check("pkt3_f1", log_q[1], {4'd2, 1'b0, 1'b0, 32'hA2});
            check("pkt3_f2", log_q[2], {4'd2, 1'b0, 1'b1, 32'hA3});
        end

        // Single-flit packet to dest 1
        log_q.delete();
        send(1'b1, 1'b1, 3'd1, 32'hB1, p);
        wait_drain("single");
        check("single_count", log_q.size(), 1);
        if (log_q.size() == 1) check("single_f0", log_q[0], {4'd3, 1'b1, 1'b1, 32'hB1});
        check("single_no_err", seen_orphans + seen_dest_errs, 0);

        // Full buffer with a stalled switch
        log_q.delete();
        bus.out_ready = 1'b0;
        send(1'b1, 1'b0, 3'd0, 32'hC0, p);
        send(1'b0, 1'b0, 3'd0, 32'hC1, p);
        send(1'b0, 1'b0, 3'd0, 32'hC2, p);
        send(1'b0, 1'b0, 3'd0, 32'hC3, p);
        @(negedge clk);
        check("full_ready_low", bus.in_ready, 1'b0);
        bus.in_valid = 1'b1; bus.in_head = 1'b0; bus.in_tail = 1'b1;
        bus.in_dest = 3'd0; bus.in_data = 32'hC4;
        repeat (3) begin
            @(negedge clk);
            check("full_blocked", bus.in_ready, 1'b0);
        end
        check("full_front", {bus.out_valid, bus.out_data}, {1'b1, 32'hC0});
        @(posedge clk); #1 bus.out_ready = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                model_accept(1'b0, 1'b1, 3'd0, 32'hC4);
                acc = 1'b1;
                break;
            end
        end
        @(posedge clk); #1 bus.in_valid = 1'b0;
        check("full_fifth_accepted", acc, 1'b1);
        wait_drain("full");
        check("full_count", log_q.size(), 5);
        if (log_q.size() == 5) begin
            check("full_f0", log_q[0].data, 32'hC0);
            check("full_f3", log_q[3].data, 32'hC3);
            check("full_f4", {log_q[4].tail, log_q[4].data}, {1'b1, 32'hC4});
        end

        // Orphan body flit, then a normal packet
        log_q.delete();
        send(1'b0, 1'b0, 3'd1, 32'hD0, p);
        send(1'b1, 1'b1, 3'd3, 32'hD1, p);
        wait_drain("orphan");
        check("orphan_pulses", seen_orphans, 1);
        check("orphan_count", log_q.size(), 1);
        if (log_q.size() == 1) check("orphan_next", log_q[0], {4'd3, 1'b1, 1'b1, 32'hD1});

        // Out-of-range destination
        log_q.delete();
        send(1'b1, 1'b1, 3'd7, 32'hE0, p);
        wait_drain("baddest");
        check("baddest_pulses", seen_dest_errs, 1);
        check("baddest_count", log_q.size(), 1);
        if (log_q.size() == 1) check("baddest_f0", log_q[0], {4'd0, 1'b1, 1'b1, 32'hE0});

        // Table rewrite while a packet is in flight
        log_q.delete();
        bus.out_ready = 1'b0;
        send(1'b1, 1'b0, 3'd2, 32'hF0, p);
        repeat (3) @(posedge clk);
        #1 rt[2] = 4'd4;
        send(1'b0, 1'b1, 3'd2, 32'hF1, p);
        bus.out_ready = 1'b1;
        wait_drain("tblchg");
        rt[2] = 4'd2;
        check("tblchg_count", log_q.size(), 2);
        if (log_q.size() == 2) check("tblchg_ports", {log_q[0].port, log_q[1].port}, 8'h22);

        // Reset with a partial packet buffered
        bus.out_ready = 1'b0;
        send(1'b1, 1'b0, 3'd2, 32'h60, p);
        send(1'b0, 1'b0, 3'd2, 32'h61, p);
        repeat (3) @(negedge clk);
        check("prerst_valid", bus.out_valid, 1'b1);
        @(posedge clk); #3 rst_n = 1'b0;
        exp_q.delete(); in_pkt = 1'b0;
        #1;
        check("midrst_valid", bus.out_valid, 1'b0);
        check("midrst_ready", bus.in_ready, 1'b0);
        check("midrst_port", bus.out_port, 4'd0);
        @(posedge clk); #1 rst_n = 1'b1; bus.out_ready = 1'b1;
        log_q.delete();
        send(1'b1, 1'b0, 3'd3, 32'h70, p);
        send(1'b0, 1'b1, 3'd3, 32'h71, p);
        wait_drain("postrst");
        check("postrst_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("postrst_f0", log_q[0], {4'd3, 1'b1, 1'b0, 32'h70});
            check("postrst_f1", log_q[1], {4'd3, 1'b0, 1'b1, 32'h71});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        tests++; fails++;
        $display("FAIL watchdog: bench did not complete in time");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
